// File: rtl/load_down_counter_if.sv
// Control and status bundle for load_down_counter: load/enable/mode inputs,
// count and status outputs.
interface load_down_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] in;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             zero;

  modport master (
    output load, in, en, auto_reload,
    input  Q, busy, tc, zero
  );

  modport slave (
    input  load, in, en, auto_reload,
    output Q, busy, tc, zero
  );
endinterface

// File: rtl/load_down_counter.sv
// Loadable down-counter/timer: counts a captured value down to zero, pulses tc,
// then stops (one-shot) or reloads the captured value (periodic).
module load_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               clear_n,
  load_down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic             r_tc;
  logic             r_busy;
  logic             w_expire;

  assign w_expire = (r_q == WIDTH'(1));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rld   <= '0;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.load) begin
        // A load overrides any expiry happening on the same edge.
        r_q   <= bus.in;
        r_rld <= bus.in;
        if (bus.in != '0) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else if (r_state == RUN && bus.en) begin
        if (w_expire) begin
          r_tc <= 1'b1;
          if (bus.auto_reload) begin
            r_q <= r_rld;
          end else begin
            r_q     <= '0;
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end else begin
          r_q <= r_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.Q    = r_q;
  assign bus.busy = r_busy;
  assign bus.tc   = r_tc;
  assign bus.zero = (r_q == '0);

endmodule

// File: tb/tb_load_down_counter.sv
// Self-checking bench for load_down_counter: directed table, corner sequences
// and randomized traffic against a behavioural model.
module tb_load_down_counter;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic clear_n = 1'b0;

  load_down_counter_if #(.WIDTH(W)) bus ();

  load_down_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         ld;
    logic [W-1:0] din;
    logic         en;
    logic         ar;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: remaining count, captured period, running flag.
  int  m_q, m_rld;
  bit  m_run, m_tc;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int q, input int tc, input int busy);
    chk({tag, ".Q"},    int'(bus.Q),    q);
    chk({tag, ".tc"},   int'(bus.tc),   tc);
    chk({tag, ".busy"}, int'(bus.busy), busy);
    chk({tag, ".zero"}, int'(bus.zero), (q == 0) ? 1 : 0);
  endtask

  task automatic step(input logic ld, input logic [W-1:0] din, input logic en, input logic ar);
    bus.load        = ld;
    bus.in          = din;
    bus.en          = en;
    bus.auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ld, input int din, input logic en, input logic ar,
                              input int q, input logic tc, input logic busy);
    vec_t v;
    v.ld = ld; v.din = W'(din); v.en = en; v.ar = ar;
    v.q = W'(q); v.tc = tc; v.busy = busy;
    return v;
  endfunction

  task automatic model_step(input bit ld, input int din, input bit en, input bit ar);
    m_tc = 1'b0;
    if (ld) begin
      m_q   = din;
      m_rld = din;
      m_run = (din != 0);
    end else if (m_run && en) begin
      if (m_q - 1 == 0) begin
        m_tc = 1'b1;
        if (ar) m_q = m_rld;
        else begin
          m_q   = 0;
          m_run = 1'b0;
        end
      end else begin
        m_q = m_q - 1;
      end
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.in = '0; bus.en = 1'b0; bus.auto_reload = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0);
    clear_n = 1'b1;
    @(posedge clk); #1;

    // One-shot in=3
    tbl.push_back(mk(1, 3, 1, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    // Enable gating, load 4, en 1,0,0,1,1,1
    tbl.push_back(mk(1, 4, 0, 0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    // Load wins over expiry, then load zero
    tbl.push_back(mk(1, 2, 1, 1, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 7, 1, 1, 7, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 6, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    // Load 1, periodic: tc every cycle; then one-shot expiry
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    // Reload uses captured value, not current in
    tbl.push_back(mk(1, 2, 1, 1, 2, 0, 1));
    tbl.push_back(mk(0, 9, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 9, 1, 1, 2, 1, 1));
    tbl.push_back(mk(0, 9, 1, 1, 1, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].din, tbl[i].en, tbl[i].ar);
      chk_all($sformatf("tbl%0d", i), tbl[i].q, tbl[i].tc, tbl[i].busy);
    end

    // Periodic at full scale: tc every 15 cycles, Q = 15 in tc cycle
    step(1'b1, 4'hF, 1'b1, 1'b1);
    chk_all("per.load", 15, 0, 1);
    for (int c = 1; c <= 45; c++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      chk_all($sformatf("per%0d", c), (c % 15 == 0) ? 15 : 15 - (c % 15),
              (c % 15 == 0) ? 1 : 0, 1);
    end

    // Asynchronous reset mid-count at Q = 5
    step(1'b1, 4'd8, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0);
    chk_all("pre_rst", 5, 0, 1);
    #2 clear_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0);
    @(posedge clk); #1;
    chk_all("rst_hold", 0, 0, 0);
    #3 clear_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      chk_all($sformatf("post_rst%0d", c), 0, 0, 0);
    end

    // Randomized traffic against the model (state is known-reset here)
    m_q = 0; m_rld = 0; m_run = 1'b0; m_tc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit ld, en, ar;
      int din;
      ld  = ($urandom_range(0, 9) == 0);
      din = $urandom_range(0, (1 << W) - 1);
      if ($urandom_range(0, 5) == 0) din = $urandom_range(0, 1);
      en  = ($urandom_range(0, 3) != 0);
      ar  = ($urandom_range(0, 2) != 0);
      step(ld, W'(din), en, ar);
      model_step(ld, din, en, ar);
      chk_all($sformatf("rnd%0d", c), m_q, m_tc ? 1 : 0, m_run ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
